qspi_multi_ctrl: RTL

QSPI_MULTI_CTRL -- requirements
Module: qspi_multi_ctrl

---
 rtl/qspi_pkg.sv | 19 +
 rtl/qspi_shift_nibble.sv | 27 ++
 rtl/qspi_multi_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/qspi_pkg.sv
// Shared definitions for the multi-device QSPI controller: FSM state codes,
// phase counter width and output-enable patterns.
package qspi_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DUMMY = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_DESEL = 3'd5;

    // Remaining-SPI-clocks counter per phase; 8 bits covers any practical phase length.
    localparam int CNT_W = 8;

    localparam logic [3:0] OE_OFF    = 4'b0000;
    localparam logic [3:0] OE_SINGLE = 4'b0001;
    localparam logic [3:0] OE_QUAD   = 4'b1111;

endpackage

// File: rtl/qspi_shift_nibble.sv
// Nibble-wide shift register: parallel load, shift-out (top nibble leaves,
// zero fills) and shift-in (new nibble enters at the bottom).
module qspi_shift_nibble #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift_out,
    input  logic         shift_in,
    input  logic [3:0]   din,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= load_val;
        else if (shift_out)
            q <= {q[W-5:0], 4'h0};
        else if (shift_in)
            q <= {q[W-5:0], din};
    end

endmodule

// File: rtl/qspi_multi_ctrl.sv
// QSPI master for several devices on shared data lines: single-bit command,
// quad address, optional dummy clocks, quad data; one SPI clock = two clk cycles.
module qspi_multi_ctrl #(
    parameter int NUM_CS       = 3,
    parameter int ADDR_BITS    = 24,
    parameter int DUMMY_CYCLES = 4,
    parameter int MAX_BYTES    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(NUM_CS)-1:0]    cs_sel,
    input  logic [7:0]                   cmd,
    input  logic [ADDR_BITS-1:0]         addr,
    input  logic                         is_write,
    input  logic [$clog2(MAX_BYTES+1)-1:0] nbytes,
    input  logic [8*MAX_BYTES-1:0]       wdata,
    input  logic                         stop,
    output logic                         busy,
    output logic                         done,
    output logic [8*MAX_BYTES-1:0]       rdata,
    input  logic [3:0]                   spi_data_in,
    output logic [3:0]                   spi_data_out,
    output logic [3:0]                   spi_data_oe,
    output logic                         spi_clk_out,
    output logic [NUM_CS-1:0]            spi_select_n
);
    import qspi_pkg::*;

    localparam int DW  = 8 * MAX_BYTES;
    localparam int SRW = (ADDR_BITS > DW) ? ADDR_BITS : DW;
    localparam int NBW = $clog2(MAX_BYTES + 1);
    localparam int CSW = $clog2(NUM_CS);

    logic [2:0]       state;
    logic             ph;
    logic             stop_pend;
    logic             wr_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dcnt;
    logic [7:0]       cmd_sr;
    logic [CSW-1:0]   cs_q;
    logic [NBW-1:0]   n_q;
    logic [NBW-1:0]   n_clamp;
    logic [DW-1:0]    wdata_q;
    logic [DW-1:0]    wswap;
    logic [DW-1:0]    rd_cur;
    logic [DW-1:0]    rd_hold;
    logic [SRW-1:0]   sr_q;
    logic [SRW-1:0]   sr_load_val;
    logic             sr_load, sr_shift_out, sr_shift_in;
    logic             active, spi_end, abort, last, enter_data;

    always_comb begin
        n_clamp = nbytes;
        if (nbytes == '0)
            n_clamp = NBW'(1);
        else if (int'(nbytes) > MAX_BYTES)
            n_clamp = NBW'(MAX_BYTES);
    end

    // Byte 0 must leave first, so it goes to the top of the shift register.
    always_comb begin
        wswap = '0;
        for (int i = 0; i < MAX_BYTES; i++)
            wswap[(MAX_BYTES-1-i)*8 +: 8] = wdata_q[i*8 +: 8];
    end

    assign active     = (state == ST_CMD) || (state == ST_ADDR) ||
                        (state == ST_DUMMY) || (state == ST_DATA);
    assign spi_end    = active && ph;
    assign abort      = stop_pend || stop;
    assign last       = (cnt == '0);
    assign dcnt       = CNT_W'({n_q, 1'b0}) - CNT_W'(1);
    assign enter_data = spi_end && !abort && last &&
                        ((state == ST_ADDR && (wr_q || DUMMY_CYCLES == 0)) ||
                         state == ST_DUMMY);

    // One shift register carries the address, then write data or read data.
    assign sr_load      = (state == ST_IDLE && start) || enter_data;
    assign sr_shift_out = spi_end && !abort && !last &&
                          (state == ST_ADDR || (state == ST_DATA && wr_q));
    assign sr_shift_in  = spi_end && state == ST_DATA && !wr_q;

    always_comb begin
        if (state == ST_IDLE)
            sr_load_val = SRW'(addr) << (SRW - ADDR_BITS);
        else if (wr_q)
            sr_load_val = SRW'(wswap) << (SRW - DW);
        else
            sr_load_val = '0;
    end

    qspi_shift_nibble #(.W(SRW)) u_sr (
        .clk       (clk),
        .rst       (rst),
        .load      (sr_load),
        .load_val  (sr_load_val),
        .shift_out (sr_shift_out),
        .shift_in  (sr_shift_in),
        .din       (spi_data_in),
        .q         (sr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ph        <= 1'b0;
            stop_pend <= 1'b0;
            wr_q      <= 1'b0;
            cnt       <= '0;
            cmd_sr    <= '0;
            cs_q      <= '0;
            n_q       <= '0;
            wdata_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    state     <= ST_CMD;
                    ph        <= 1'b0;
                    stop_pend <= 1'b0;
                    cnt       <= CNT_W'(7);
                    cmd_sr    <= cmd;
                    cs_q      <= cs_sel;
                    n_q       <= n_clamp;
                    wr_q      <= is_write;
                    wdata_q   <= wdata;
                end
                ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
                    stop_pend <= stop_pend || stop;
                    if (!ph) begin
                        ph <= 1'b1;
                    end else begin
                        ph <= 1'b0;
                        if (abort) begin
                            state <= ST_DESEL;
                        end else if (!last) begin
                            cnt <= cnt - CNT_W'(1);
                            if (state == ST_CMD)
                                cmd_sr <= {cmd_sr[6:0], 1'b0};
                        end else begin
                            case (state)
                                ST_CMD: begin
                                    state <= ST_ADDR;
                                    cnt   <= CNT_W'(ADDR_BITS/4 - 1);
                                end
                                ST_ADDR: if (!wr_q && DUMMY_CYCLES > 0) begin
                                    state <= ST_DUMMY;
                                    cnt   <= CNT_W'(DUMMY_CYCLES - 1);
                                end else begin
                                    state <= ST_DATA;
                                    cnt   <= dcnt;
                                end
                                ST_DUMMY: begin
                                    state <= ST_DATA;
                                    cnt   <= dcnt;
                                end
                                default: state <= ST_DESEL;
                            endcase
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The first received byte sits deepest in the register once all nibbles are in.
    always_comb begin
        rd_cur = '0;
        for (int i = 0; i < MAX_BYTES; i++)
            if (i < int'(n_q))
                rd_cur[i*8 +: 8] = sr_q[(int'(n_q)-1-i)*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_hold <= '0;
        else if (state == ST_DESEL && !wr_q)
            rd_hold <= rd_cur;
    end

    assign rdata = (state == ST_DESEL && !wr_q) ? rd_cur : rd_hold;

    always_comb begin
        spi_data_out = 4'h0;
        spi_data_oe  = OE_OFF;
        case (state)
            ST_CMD: begin
                spi_data_out = {3'b000, cmd_sr[7]};
                spi_data_oe  = OE_SINGLE;
            end
            ST_ADDR: begin
                spi_data_out = sr_q[SRW-1 -: 4];
                spi_data_oe  = OE_QUAD;
            end
            ST_DATA: if (wr_q) begin
                spi_data_out = sr_q[SRW-1 -: 4];
                spi_data_oe  = OE_QUAD;
            end
            default: ;
        endcase
    end

    assign busy         = active;
    assign done         = (state == ST_DESEL);
    assign spi_clk_out  = active && ph;
    assign spi_select_n = active ? ~(NUM_CS'(1) << cs_q) : '1;

endmodule
